// File: rtl/int_dispatch_if.sv
// int_dispatch_if: groups the core-side interrupt handshake and the 8-bit
// Wishbone register window of int_dispatch.
//   Core handshake : CPU_BND, CPU_PC, IRQ_REQ, IRQ_VEC, IRQ_ACK, RETI, EPC
//   Wishbone slave : WB_ADRi, WB_DATi, WB_DATo, WB_WEi, WB_CYCi, WB_STBi, WB_ACKo
// The slave modport is the dispatcher's view; the master modport is the view
// of the core / bus master that drives it.
interface int_dispatch_if;
  logic        CPU_BND;
  logic [23:0] CPU_PC;
  logic        IRQ_REQ;
  logic [23:0] IRQ_VEC;
  logic        IRQ_ACK;
  logic        RETI;
  logic [23:0] EPC;

  logic [2:0]  WB_ADRi;
  logic [7:0]  WB_DATi;
  logic [7:0]  WB_DATo;
  logic        WB_WEi;
  logic        WB_CYCi;
  logic        WB_STBi;
  logic        WB_ACKo;

  modport slave (
    input  CPU_BND, CPU_PC, IRQ_ACK, RETI,
    input  WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
    output IRQ_REQ, IRQ_VEC, EPC, WB_DATo, WB_ACKo
  );

  modport master (
    output CPU_BND, CPU_PC, IRQ_ACK, RETI,
    output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
    input  IRQ_REQ, IRQ_VEC, EPC, WB_DATo, WB_ACKo
  );
endinterface

// File: rtl/int_dispatch.sv
// int_dispatch: interrupt entry/exit sequencer between the peripheral
// interrupt lines, the 8-source priority interrupt controller and the core.
//   clk, rst   : clock, synchronous active-high reset
//   SRC_IRQ    : raw peripheral interrupt lines (bit 7 SYSCALL .. bit 0 XINT)
//   INT_ARR_O  : registered pending vector to the controller
//   INT_I      : controller has an enabled, unmasked request
//   IVEC_I     : controller handler address
//   bus        : core handshake + Wishbone register window (slave modport)
// Register map: 0 EDGE, 1 PEND (W1C edge bits), 2 STAT {INSV,5'b0,state},
// 3/4/5 EPC bytes, 6 reserved, 7 SWI (write 1 sets edge latch).
module int_dispatch (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  SRC_IRQ,
  output logic [7:0]  INT_ARR_O,
  input  logic        INT_I,
  input  logic [23:0] IVEC_I,
  int_dispatch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    REQ     = 2'b10,
    SERVICE = 2'b11
  } state_t;

  state_t      state, state_n;
  logic        vec_load, epc_cap;
  logic        insv;
  logic        wb_wr;
  logic [7:0]  edge_r, pend_r, pend_n, src_d;
  logic [7:0]  rise, swi_set, pend_clr;
  logic [23:0] irq_vec_r, epc_r;

  assign wb_wr    = bus.WB_CYCi & bus.WB_STBi & bus.WB_WEi;
  assign rise     = SRC_IRQ & ~src_d;
  assign swi_set  = (wb_wr && bus.WB_ADRi == 3'd7) ? bus.WB_DATi : 8'h00;
  assign pend_clr = (wb_wr && bus.WB_ADRi == 3'd1) ? bus.WB_DATi : 8'h00;

  // Edge sources hold a sticky latch (set beats W1C clear in the same cycle);
  // level sources simply follow the registered raw line.
  assign pend_n = (edge_r & ((pend_r & ~pend_clr) | rise | swi_set))
                | (~edge_r & SRC_IRQ);

  assign insv = (state == SERVICE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src_d     <= 8'h00;
      pend_r    <= 8'h00;
      edge_r    <= 8'h00;
      irq_vec_r <= 24'h000000;
      epc_r     <= 24'h000000;
    end else begin
      state  <= state_n;
      src_d  <= SRC_IRQ;
      pend_r <= pend_n;
      if (wb_wr && bus.WB_ADRi == 3'd0)
        edge_r <= bus.WB_DATi;
      if (vec_load)
        irq_vec_r <= IVEC_I;
      // A return address captured on IRQ_ACK overrides a concurrent
      // software write to the EPC bytes.
      if (epc_cap) begin
        epc_r <= bus.CPU_PC;
      end else if (wb_wr) begin
        case (bus.WB_ADRi)
          3'd3:    epc_r[7:0]   <= bus.WB_DATi;
          3'd4:    epc_r[15:8]  <= bus.WB_DATi;
          3'd5:    epc_r[23:16] <= bus.WB_DATi;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_n  = state;
    vec_load = 1'b0;
    epc_cap  = 1'b0;
    case (state)
      IDLE: begin
        if (INT_I)
          state_n = ARMED;
      end
      ARMED: begin
        // Controller request may vanish before the core reaches a boundary.
        if (!INT_I) begin
          state_n = IDLE;
        end else if (bus.CPU_BND) begin
          state_n  = REQ;
          vec_load = 1'b1;
        end
      end
      REQ: begin
        // Once offered, the request is held until the core takes it.
        if (bus.IRQ_ACK) begin
          state_n = SERVICE;
          epc_cap = 1'b1;
        end
      end
      SERVICE: begin
        // No nesting: controller requests are ignored until RETI.
        if (bus.RETI)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    case (bus.WB_ADRi)
      3'd0:    bus.WB_DATo = edge_r;
      3'd1:    bus.WB_DATo = pend_r;
      3'd2:    bus.WB_DATo = {insv, 5'b00000, state};
      3'd3:    bus.WB_DATo = epc_r[7:0];
      3'd4:    bus.WB_DATo = epc_r[15:8];
      3'd5:    bus.WB_DATo = epc_r[23:16];
      default: bus.WB_DATo = 8'h00;
    endcase
  end

  assign bus.WB_ACKo = bus.WB_CYCi & bus.WB_STBi;
  assign bus.IRQ_REQ = (state == REQ);
  assign bus.IRQ_VEC = irq_vec_r;
  assign bus.EPC     = epc_r;
  assign INT_ARR_O   = pend_r;

endmodule

// File: doc/int_dispatch.md
# int_dispatch

Interrupt entry/exit sequencer placed between the SoC peripheral interrupt lines, the 8-source priority interrupt controller and the KC-LS1u core. It conditions raw source lines (level or rising-edge, per source) into pending bits, drives them to the controller, and turns the controller's INT/vector outputs into a clean request/acknowledge handshake at a CPU instruction boundary. It also captures the return address and blocks re-entry until the core signals return-from-interrupt. Software sees an 8-bit Wishbone register window.

## Interface
- No parameters; source count fixed at 8, address width fixed at 24.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- SRC_IRQ  in  8  raw peripheral interrupt lines (SYSCALL..XINT, bit 7..0)
- INT_ARR_O  out  8  pending vector to interrupt controller INT_ARR (registered)
- INT_I  in  1  controller INT (enabled, unmasked request present)
- IVEC_I  in  24  controller IVEC_ADDR
- CPU_BND  in  1  core at instruction boundary, safe to divert
- CPU_PC  in  24  address of next instruction the core would execute
- IRQ_REQ  out  1  interrupt request to core
- IRQ_VEC  out  24  handler address, stable while IRQ_REQ=1
- IRQ_ACK  in  1  core accepted request, jumping to IRQ_VEC this cycle
- RETI  in  1  core executing return-from-interrupt (1-cycle pulse)
- EPC  out  24  saved return address, to core for RETI
- WB_ADRi  in  3, WB_DATi  in  8, WB_DATo  out  8, WB_WEi  in  1, WB_CYCi  in  1, WB_STBi  in  1, WB_ACKo  out  1  Wishbone slave

## Operation
- Registers (WB_ADRi): 0 EDGE (1=rising-edge source, 0=level; RW, reset 00); 1 PEND (read pending; write 1 clears edge-latched bits, level bits unaffected); 2 STAT (read {INSV, 5'b0, state[1:0]}, INSV bit 7); 3/4/5 EPC[7:0]/[15:8]/[23:16] (RW); 6 reads 00, writes ignored; 7 SWI (write 1 sets edge-latch bit; read 00).
- Edge detect: src_d <= SRC_IRQ each cycle, reset 00. Edge source: latch set on SRC_IRQ & ~src_d or SWI write; cleared by PEND W1C. Set wins over clear in same cycle. Level source: PEND bit = registered SRC_IRQ, SWI ignored.
- INT_ARR_O = PEND register; reset 00.
- FSM, reset IDLE (00):
  - IDLE: INT_I=1 -> ARMED.
  - ARMED (01): INT_I=0 -> IDLE; else CPU_BND=1 -> REQ, IRQ_VEC <= IVEC_I.
  - REQ (10): IRQ_REQ=1; IRQ_ACK=1 -> SERVICE, EPC <= CPU_PC, INSV <= 1. Request never withdrawn once in REQ.
  - SERVICE (11): INSV=1; RETI=1 -> IDLE, INSV <= 0. INT_I ignored (no nesting).
- IRQ_ACK outside REQ and RETI outside SERVICE ignored.
- EPC Wishbone write in the cycle IRQ_ACK is captured: capture wins.
- Source clearing is software's job (PEND W1C or peripheral clear) before RETI.
- WB_ACKo = WB_CYCi & WB_STBi (zero wait state); WB_DATo combinational from WB_ADRi.

## Timing
- Reset values: IRQ_REQ 0, IRQ_VEC 000000, EPC 000000, INT_ARR_O 00, INSV 0, state IDLE, EDGE 00.
- rst mid-operation (any state) -> all of the above at next edge; pending edge latches lost.
- SRC_IRQ edge sampled at edge k -> PEND/INT_ARR_O bit at edge k+1.
- INT_I high at edge k (IDLE) -> ARMED at k+1; CPU_BND high at edge k+1 -> IRQ_REQ high after edge k+2. Minimum INT_I-to-IRQ_REQ latency 2 cycles.
- IRQ_REQ drops and EPC valid after the edge sampling IRQ_ACK.
- RETI at edge k -> IDLE after k; new request possible from edge k+1 (IRQ_REQ no earlier than k+3).
- Source high when rst deasserts counts as a rising edge (src_d reset 0).

## Test plan
- EDGE=01, controller enabled for bit 0, IVEC_I=001000, CPU_BND=1: pulse SRC_IRQ[0] -> PEND=01, IRQ_REQ=1 with IRQ_VEC=001000; IRQ_ACK with CPU_PC=000345 -> EPC=000345, STAT=83.
- In SERVICE, raise SRC_IRQ[3] (level) -> PEND=09, IRQ_REQ stays 0; write PEND=01, pulse RETI -> IDLE, then new IRQ_REQ for source 3 within 3 cycles.
- ARMED with CPU_BND=0, drop INT_I -> state returns IDLE, IRQ_REQ never asserted.
- Edge source 5: SRC_IRQ[5] rising in same cycle as PEND write 20 -> PEND bit 5 remains 1; SWI write 20 with EDGE=20 -> PEND=20.
- Write EPC regs 56,34,12 in SERVICE -> EPC=123456; RETI/IRQ_ACK pulses in wrong states -> no state change.
- Assert rst during REQ -> IRQ_REQ 0, PEND 00, state IDLE, EPC 000000 next cycle.
